// File: rtl/hex_display_pkg.sv
// Shared types and constants for the HEX display writer.
package hex_display_pkg;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment codes, bit0 = a .. bit6 = g, indexed by nibble value.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // HEX slave data register layout: segment code in the low seven bits.
  function automatic logic [31:0] pack_writedata(input logic [6:0] seg);
    return {25'b0, seg};
  endfunction

endpackage

// File: rtl/avalon_hex_display_writer_if.sv
// Avalon-MM initiator bus towards the HEX output-port slaves.
interface avalon_hex_display_writer_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic              avm_read_n;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata,
    output avm_readdata, avm_waitrequest
  );

endinterface

// File: rtl/hex7seg_encode.sv
// Nibble to active-low seven-segment code, with blanking override.
module hex7seg_encode
  import hex_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins over the nibble value.
  always_comb begin
    seg_o = blank_i ? SEG_BLANK : SEG_LUT[nibble_i];
  end

endmodule

// File: rtl/avalon_hex_display_writer.sv
// Writes a packed hex value to NUM_DIGITS HEX slaves, one Avalon write per
// digit, with optional per-digit readback check.
module avalon_hex_display_writer
  import hex_display_pkg::*;
#(
  parameter int unsigned        NUM_DIGITS  = 6,
  parameter int unsigned        ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0]  ADDR_STRIDE = ADDR_W'(32'h10)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [4*NUM_DIGITS-1:0] cmd_value,
  input  logic [NUM_DIGITS-1:0]   cmd_blank,
  input  logic                    cmd_verify,
  output logic                    done,
  output logic                    error,
  avalon_hex_display_writer_if.master avm
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] value_q, value_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    verify_q, verify_d;
  logic                    error_q, error_d;

  logic [4*NUM_DIGITS-1:0] value_shift;
  logic [3:0]              nibble;
  logic [6:0]              seg;
  logic                    last_digit;

  // Digit 0 takes the most significant nibble so the value reads left to right.
  always_comb begin
    value_shift = value_q << {idx_q, 2'b00};
    nibble      = value_shift[4*NUM_DIGITS-1 -: 4];
    last_digit  = (idx_q == IdxW'(NUM_DIGITS - 1));
  end

  hex7seg_encode u_encode (
    .nibble_i (nibble),
    .blank_i  (blank_q[idx_q]),
    .seg_o    (seg)
  );

  // State and command registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      value_q  <= '0;
      blank_q  <= '0;
      verify_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      blank_q  <= blank_d;
      verify_q <= verify_d;
      error_q  <= error_d;
    end
  end

  // Next-state: sequence write (and optional readback) per digit.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    value_d  = value_q;
    blank_d  = blank_q;
    verify_d = verify_q;
    error_d  = error_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          value_d  = cmd_value;
          blank_d  = cmd_blank;
          verify_d = cmd_verify;
          error_d  = 1'b0;
          idx_d    = '0;
          state_d  = StWrite;
        end
      end
      StWrite: begin
        if (!avm.avm_waitrequest) begin
          if (verify_q) begin
            state_d = StRead;
          end else if (last_digit) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StWrite;
          end
        end
      end
      StRead: begin
        if (!avm.avm_waitrequest) begin
          if (avm.avm_readdata != pack_writedata(seg)) begin
            error_d = 1'b1;
          end
          if (last_digit) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StWrite;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus and status outputs are decoded from the registered state only.
  always_comb begin
    cmd_ready          = (state_q == StIdle);
    done               = (state_q == StDone);
    error              = error_q;
    avm.avm_address    = BASE_ADDR + ADDR_W'(idx_q) * ADDR_STRIDE;
    avm.avm_chipselect = (state_q == StWrite) || (state_q == StRead);
    avm.avm_write_n    = (state_q != StWrite);
    avm.avm_read_n     = (state_q != StRead);
    avm.avm_writedata  = (state_q == StWrite) ? pack_writedata(seg) : 32'h0;
  end

endmodule

// File: tb/tb_avalon_hex_display_writer.sv
// Directed bench for avalon_hex_display_writer with an in-process slave model.
module tb_avalon_hex_display_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_verify, done, error;
  logic [23:0] cmd_value;
  logic [5:0]  cmd_blank;

  avalon_hex_display_writer_if #(.ADDR_W(32)) avm ();

  avalon_hex_display_writer #(
    .NUM_DIGITS  (6),
    .ADDR_W      (32),
    .BASE_ADDR   (32'h0),
    .ADDR_STRIDE (32'h10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_value  (cmd_value),
    .cmd_blank  (cmd_blank),
    .cmd_verify (cmd_verify),
    .done       (done),
    .error      (error),
    .avm        (avm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nwr, nrd, nx, nacc, ndone, acc_cyc, done_cyc, nstall, stall_viol;
  int proto_bad = 0;
  int stall_idx = -1;
  int stall_left = 0;
  int corrupt_idx = -1;
  logic        err_at_done;
  logic        have_snap;
  logic [31:0] snap_addr, snap_data;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic        kind [64];
  logic [31:0] mem [8];

  task automatic clear_log();
    nwr = 0; nrd = 0; nx = 0; nacc = 0; ndone = 0;
    acc_cyc = -1; done_cyc = -1; nstall = 0; stall_viol = 0;
    have_snap = 1'b0; err_at_done = 1'b0;
  endtask

  // One clock cycle: slave responds, bus is sampled mid-cycle, then the edge.
  task automatic tick();
    logic wr, rd;
    int   di;
    di = int'(avm.avm_address[6:4]);
    wr = avm.avm_chipselect && !avm.avm_write_n;
    rd = avm.avm_chipselect && !avm.avm_read_n;
    avm.avm_waitrequest = wr && (stall_left > 0) && (di == stall_idx);
    avm.avm_readdata    = (rd && di == corrupt_idx) ? 32'h0000_0080 : mem[di];
    #1;
    if (!avm.avm_write_n && !avm.avm_read_n) proto_bad++;
    if (avm.avm_chipselect && avm.avm_write_n && avm.avm_read_n) proto_bad++;
    if (cmd_ready && avm.avm_chipselect) proto_bad++;
    if (done && (cmd_ready || avm.avm_chipselect)) proto_bad++;
    if (wr) begin
      if (have_snap && (avm.avm_address !== snap_addr || avm.avm_writedata !== snap_data))
        stall_viol++;
      have_snap = avm.avm_waitrequest;
      snap_addr = avm.avm_address;
      snap_data = avm.avm_writedata;
      if (avm.avm_waitrequest) begin
        nstall++;
      end else begin
        if (nwr < 64) begin
          wr_addr[nwr] = avm.avm_address;
          wr_data[nwr] = avm.avm_writedata;
        end
        if (nx < 64) kind[nx] = 1'b0;
        nwr++; nx++;
        mem[di] = avm.avm_writedata;
      end
    end else begin
      have_snap = 1'b0;
    end
    if (rd && !avm.avm_waitrequest) begin
      if (nx < 64) kind[nx] = 1'b1;
      nrd++; nx++;
    end
    if (cmd_valid && cmd_ready && !reset) begin
      nacc++;
      acc_cyc = cyc;
    end
    if (done) begin
      ndone++;
      done_cyc = cyc;
      err_at_done = error;
    end
    if (avm.avm_waitrequest) stall_left--;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE; cmd_* are scrambled after accept.
  task automatic run_cmd(input logic [23:0] v, input logic [5:0] b, input logic vf);
    clear_log();
    cmd_value = v; cmd_blank = b; cmd_verify = vf; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_value = 24'hFFFFFF; cmd_blank = 6'b000000; cmd_verify = ~vf;
    for (int i = 0; i < 60 && ndone == 0; i++) tick();
    checks++;
    if (ndone == 0) begin
      failures++;
      $display("FAIL done_timeout: no done pulse within 60 cycles (value=%h)", v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({cmd_ready, done, error, avm.avm_chipselect, avm.avm_write_n, avm.avm_read_n}
        !== 6'b100011) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy/done/err/cs/wn/rn=%b want 100011",
               {cmd_ready, done, error, avm.avm_chipselect, avm.avm_write_n, avm.avm_read_n});
    end
    checks++;
    if (avm.avm_address !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr: got %h want 00000000", avm.avm_address);
    end
    checks++;
    if (avm.avm_writedata !== 32'h0) begin
      failures++;
      $display("FAIL reset_wdata: got %h want 00000000", avm.avm_writedata);
    end
  endtask

  task automatic test_writes(input logic [23:0] v, input logic [5:0] b,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3,
                             input logic [31:0] e4, input logic [31:0] e5);
    logic [31:0] exp_d [6];
    exp_d = '{e0, e1, e2, e3, e4, e5};
    run_cmd(v, b, 1'b0);
    checks++;
    if (nwr !== 6 || nrd !== 0) begin
      failures++;
      $display("FAIL write_count: got wr=%0d rd=%0d want wr=6 rd=0", nwr, nrd);
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (wr_addr[k] !== 32'(k * 16) || wr_data[k] !== exp_d[k]) begin
        failures++;
        $display("FAIL write_%0d: got addr=%h data=%h want addr=%h data=%h",
                 k, wr_addr[k], wr_data[k], 32'(k * 16), exp_d[k]);
      end
    end
    checks++;
    if (done_cyc - acc_cyc !== 7 || error !== 1'b0) begin
      failures++;
      $display("FAIL write_latency: got done-accept=%0d err=%b want 7 err=0",
               done_cyc - acc_cyc, error);
    end
  endtask

  task automatic test_verify();
    corrupt_idx = -1;
    run_cmd(24'h012345, 6'b000000, 1'b1);
    checks++;
    if (nwr !== 6 || nrd !== 6) begin
      failures++;
      $display("FAIL verify_count: got wr=%0d rd=%0d want 6 6", nwr, nrd);
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (kind[k] !== k[0]) begin
        failures++;
        $display("FAIL verify_order_%0d: got read=%b want read=%b", k, kind[k], k[0]);
      end
    end
    checks++;
    if (done_cyc - acc_cyc !== 13 || error !== 1'b0) begin
      failures++;
      $display("FAIL verify_latency: got done-accept=%0d err=%b want 13 err=0",
               done_cyc - acc_cyc, error);
    end
    corrupt_idx = 3;
    run_cmd(24'h012345, 6'b000000, 1'b1);
    corrupt_idx = -1;
    checks++;
    if (err_at_done !== 1'b1 || error !== 1'b1) begin
      failures++;
      $display("FAIL verify_error_set: got at_done=%b after=%b want 1 1", err_at_done, error);
    end
    run_cmd(24'h000000, 6'b000000, 1'b0);
    checks++;
    if (err_at_done !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL verify_error_clear: got at_done=%b after=%b want 0 0", err_at_done, error);
    end
  endtask

  task automatic test_waitrequest();
    stall_idx = 2;
    stall_left = 3;
    run_cmd(24'h012345, 6'b000000, 1'b0);
    stall_idx = -1;
    checks++;
    if (nstall !== 3 || stall_viol !== 0) begin
      failures++;
      $display("FAIL stall_hold: got stalled=%0d unstable=%0d want 3 0", nstall, stall_viol);
    end
    checks++;
    if (nwr !== 6 || wr_data[2] !== 32'h24) begin
      failures++;
      $display("FAIL stall_writes: got wr=%0d d2=%h want 6 00000024", nwr, wr_data[2]);
    end
    checks++;
    if (done_cyc - acc_cyc !== 10) begin
      failures++;
      $display("FAIL stall_latency: got done-accept=%0d want 10", done_cyc - acc_cyc);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    found = 1'b0;
    clear_log();
    cmd_value = 24'h6789AB; cmd_blank = 6'b000000; cmd_verify = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (avm.avm_chipselect && !avm.avm_write_n && avm.avm_address == 32'h40) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL mid_reach: got no digit-4 write want write at 00000040");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({cmd_ready, done, avm.avm_chipselect, avm.avm_write_n, avm.avm_read_n} !== 5'b10011
        || avm.avm_address !== 32'h0 || avm.avm_writedata !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset: got rdy/done/cs/wn/rn=%b addr=%h wd=%h want 10011 0 0",
               {cmd_ready, done, avm.avm_chipselect, avm.avm_write_n, avm.avm_read_n},
               avm.avm_address, avm.avm_writedata);
    end
    clear_log();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (nwr + nrd !== 0 || ndone !== 0) begin
      failures++;
      $display("FAIL mid_quiet: got transfers=%0d dones=%0d want 0 0", nwr + nrd, ndone);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    cmd_value = 24'h89ABCD; cmd_blank = 6'b000000; cmd_verify = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 32; i++) tick();
    cmd_valid = 1'b0;
    checks++;
    if (nacc !== 4 || ndone !== 4) begin
      failures++;
      $display("FAIL b2b_count: got accepts=%0d dones=%0d want 4 4", nacc, ndone);
    end
    checks++;
    if (nwr !== 24 || done_cyc - acc_cyc !== 7) begin
      failures++;
      $display("FAIL b2b_writes: got wr=%0d done-accept=%0d want 24 7", nwr, done_cyc - acc_cyc);
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_value = '0; cmd_blank = '0; cmd_verify = 1'b0;
    avm.avm_waitrequest = 1'b0;
    avm.avm_readdata = 32'h0;
    for (int i = 0; i < 8; i++) mem[i] = 32'h0;
    clear_log();
    @(posedge clk);
    #1;
    test_reset();
    test_writes(24'h012345, 6'b000000, 32'h40, 32'h79, 32'h24, 32'h30, 32'h19, 32'h12);
    test_writes(24'hABCDEF, 6'b100001, 32'h7F, 32'h03, 32'h46, 32'h21, 32'h06, 32'h7F);
    test_verify();
    test_waitrequest();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (proto_bad !== 0) begin
      failures++;
      $display("FAIL protocol: got %0d bad bus cycles want 0", proto_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
